sram_word_bridge: RTL and testbench

SRAM_WORD_BRIDGE -- requirements
Module: sram_word_bridge

---
 rtl/sram_word_bridge.sv | 267 ++++++++++++++++++++++++++
 tb/tb_sram_word_bridge.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_word_bridge.sv
// ---------------------------------------------------------------------------
// sram_word_bridge
//   Bridges a simple 32-bit word request interface onto an asynchronous
//   16-bit SRAM. Each word access is split into a low half-word phase (LO,
//   bytes 0-1) and a high half-word phase (HI, bytes 2-3), followed by a
//   single response cycle (RESP). Each phase is held for WAIT_CYC+1 cycles.
//   Phases whose byte-enables are both clear may be skipped (SKIP_UNUSED).
//
// Ports
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_req/o_ready      request handshake (accept when both high)
//   i_we               1 = write, 0 = read
//   i_addr             byte address, bits [1:0] ignored
//   i_wdata, i_bmask   store data and byte enables
//   o_busy             inverse of o_ready
//   o_rvalid, o_rdata  read response pulse and held read word
//   o_wdone            write completion pulse
//   SRAM_*             active-low SRAM bus (all bus outputs are registered)
// ---------------------------------------------------------------------------
module sram_word_bridge #(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYC    = 0,
  parameter int SKIP_UNUSED = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req,
  input  logic               i_we,
  input  logic [SRAM_AW:0]   i_addr,
  input  logic [31:0]        i_wdata,
  input  logic [3:0]         i_bmask,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_rvalid,
  output logic [31:0]        o_rdata,
  output logic               o_wdone,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_D,
  input  logic [15:0]        SRAM_Q,
  output logic               SRAM_CE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_UB_N
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic       SKIP      = (SKIP_UNUSED != 0);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC);

  state_e               state_q, state_d;
  logic [3:0]           wait_q, wait_d;
  logic                 we_q, we_d;
  logic [SRAM_AW-2:0]   word_q, word_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           bmask_q, bmask_d;
  logic [31:0]          rbuf_q, rbuf_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 wdone_q, wdone_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [15:0]          dout_q, dout_d;
  logic                 ce_n_q, ce_n_d;
  logic                 we_n_q, we_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 lb_n_q, lb_n_d;
  logic                 ub_n_q, ub_n_d;
  logic                 phase_last_s;
  logic                 addr_lsb_unused;

  // Word alignment: the two byte-offset bits carry no information.
  assign addr_lsb_unused = ^i_addr[1:0];

  // First state after accepting a request with byte mask bm.
  function automatic state_e first_phase(input logic [3:0] bm);
    if (!SKIP || (bm[1:0] != 2'b00)) begin
      return ST_LO;
    end else if (bm[3:2] != 2'b00) begin
      return ST_HI;
    end else begin
      return ST_RESP;
    end
  endfunction

  // Expand a 2-bit byte-enable pair into a 16-bit data mask.
  function automatic logic [15:0] half_mask(input logic [1:0] bm);
    return {{8{bm[1]}}, {8{bm[0]}}};
  endfunction

  // Next-state, request latching, read capture and bus output decode.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    we_d     = we_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    bmask_d  = bmask_q;
    rbuf_d   = rbuf_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wdone_d  = 1'b0;
    addr_d   = addr_q;
    dout_d   = 16'h0000;
    ce_n_d   = 1'b1;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    phase_last_s = (wait_q == WAIT_LAST);

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          we_d    = i_we;
          word_d  = i_addr[SRAM_AW:2];
          wdata_d = i_wdata;
          bmask_d = i_bmask;
          rbuf_d  = 32'h0000_0000;
          state_d = first_phase(i_bmask);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LO: begin
        if (phase_last_s) begin
          // The SRAM output is sampled in the final cycle of the phase.
          if (!we_q) begin
            rbuf_d[15:0] = SRAM_Q & half_mask(bmask_q[1:0]);
          end else begin
            rbuf_d[15:0] = rbuf_q[15:0];
          end
          if (SKIP && (bmask_q[3:2] == 2'b00)) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_HI;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_HI: begin
        if (phase_last_s) begin
          if (!we_q) begin
            rbuf_d[31:16] = SRAM_Q & half_mask(bmask_q[3:2]);
          end else begin
            rbuf_d[31:16] = rbuf_q[31:16];
          end
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every phase starts counting from zero.
    if (state_d != state_q) begin
      wait_d = 4'd0;
    end else begin
      wait_d = wait_d;
    end

    // Bus outputs are decoded from the next state so they appear registered.
    case (state_d)
      ST_LO: begin
        ce_n_d = 1'b0;
        addr_d = {word_d, 1'b0};
        {ub_n_d, lb_n_d} = ~bmask_d[1:0];
        if (we_d) begin
          we_n_d = 1'b0;
          dout_d = wdata_d[15:0];
        end else begin
          oe_n_d = 1'b0;
        end
      end
      ST_HI: begin
        ce_n_d = 1'b0;
        addr_d = {word_d, 1'b1};
        {ub_n_d, lb_n_d} = ~bmask_d[3:2];
        if (we_d) begin
          we_n_d = 1'b0;
          dout_d = wdata_d[31:16];
        end else begin
          oe_n_d = 1'b0;
        end
      end
      ST_RESP: begin
        rvalid_d = ~we_d;
        wdone_d  = we_d;
        if (!we_d) begin
          rdata_d = rbuf_d;
        end else begin
          rdata_d = rdata_q;
        end
      end
      default: begin
        addr_d = addr_q;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      wait_q   <= 4'd0;
      we_q     <= 1'b0;
      word_q   <= '0;
      wdata_q  <= 32'h0000_0000;
      bmask_q  <= 4'h0;
      rbuf_q   <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      addr_q   <= '0;
      dout_q   <= 16'h0000;
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      we_q     <= we_d;
      word_q   <= word_d;
      wdata_q  <= wdata_d;
      bmask_q  <= bmask_d;
      rbuf_q   <= rbuf_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      ce_n_q   <= ce_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      lb_n_q   <= lb_n_d;
      ub_n_q   <= ub_n_d;
    end
  end

  assign o_ready   = (state_q == ST_IDLE);
  assign o_busy    = ~o_ready;
  assign o_rvalid  = rvalid_q;
  assign o_wdone   = wdone_q;
  assign o_rdata   = rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_D    = dout_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign SRAM_UB_N = ub_n_q;

endmodule

// File: tb/tb_sram_word_bridge.sv
// ---------------------------------------------------------------------------
// tb_sram_word_bridge
//   Three bridge instances share one stimulus stream:
//     inst 0: WAIT_CYC=0, SKIP_UNUSED=1
//     inst 1: WAIT_CYC=2, SKIP_UNUSED=1
//     inst 2: WAIT_CYC=1, SKIP_UNUSED=0
//   Each instance has its own behavioural SRAM. A transaction-level reference
//   model (cycle offset since accept -> phase) predicts all outputs each cycle.
// ---------------------------------------------------------------------------
module tb_sram_word_bridge;
  localparam int AW = 10;
  localparam int NI = 3;
  localparam int MD = 1 << AW;

  function automatic int wc_of(input int i);
    case (i)
      0: return 0;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int sk_of(input int i);
    return (i == 2) ? 0 : 1;
  endfunction

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mem_clr = 1'b1;
  logic            req = 1'b0;
  logic            we = 1'b0;
  logic [AW:0]     addr = '0;
  logic [31:0]     wdata = 32'h0;
  logic [3:0]      bmask = 4'h0;

  logic            rdy [NI];
  logic            busy [NI];
  logic            rv [NI];
  logic            wd [NI];
  logic [31:0]     rdat [NI];
  logic [AW-1:0]   sa [NI];
  logic [15:0]     sd [NI];
  logic [15:0]     sq [NI];
  logic            ce [NI];
  logic            wen [NI];
  logic            oen [NI];
  logic            lbn [NI];
  logic            ubn [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sram_word_bridge #(
      .SRAM_AW(AW), .WAIT_CYC(wc_of(g)), .SKIP_UNUSED(sk_of(g))
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
      .i_wdata(wdata), .i_bmask(bmask), .o_ready(rdy[g]), .o_busy(busy[g]),
      .o_rvalid(rv[g]), .o_rdata(rdat[g]), .o_wdone(wd[g]),
      .SRAM_ADDR(sa[g]), .SRAM_D(sd[g]), .SRAM_Q(sq[g]), .SRAM_CE_N(ce[g]),
      .SRAM_WE_N(wen[g]), .SRAM_OE_N(oen[g]), .SRAM_LB_N(lbn[g]), .SRAM_UB_N(ubn[g])
    );
  end

  // Behavioural asynchronous SRAMs
  logic [15:0] smem [NI][MD];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (mem_clr) begin
        for (int a = 0; a < MD; a++) smem[i][a] <= 16'h0;
      end else if (!ce[i] && !wen[i]) begin
        if (!lbn[i]) smem[i][sa[i]][7:0]  <= sd[i][7:0];
        if (!ubn[i]) smem[i][sa[i]][15:8] <= sd[i][15:8];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      sq[i] = (!ce[i] && !oen[i]) ? smem[i][sa[i]] : 16'hBAD0;
    end
  end

  // ---------------- reference model ----------------
  int            mk [NI];          // cycles since accept, 0 = idle
  logic          mwe [NI];
  logic [AW-2:0] mword [NI];
  logic [31:0]   mwd [NI];
  logic [3:0]    mbm [NI];
  logic [AW-1:0] maddr [NI];
  logic [31:0]   mrd [NI];
  logic [15:0]   rmem [NI][MD];

  function automatic int n_phases(input int i, input logic [3:0] bm);
    int p = 0;
    if (sk_of(i) == 0) return 2;
    if (bm[1:0] != 2'b00) p++;
    if (bm[3:2] != 2'b00) p++;
    return p;
  endfunction

  // 0 idle, 1 LO, 2 HI, 3 response cycle
  function automatic int phase_at(input int i, input int k, input logic [3:0] bm);
    int len = wc_of(i) + 1;
    if (k == 0) return 0;
    if (k > n_phases(i, bm) * len) return 3;
    if ((k - 1) / len == 1) return 2;
    if (sk_of(i) != 0 && bm[1:0] == 2'b00) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] read_word(input int i, input logic [AW-2:0] w, input logic [3:0] bm);
    logic [31:0] v;
    v = {rmem[i][{w, 1'b1}], rmem[i][{w, 1'b0}]};
    return v & {{8{bm[3]}}, {8{bm[2]}}, {8{bm[1]}}, {8{bm[0]}}};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (mem_clr) begin
        for (int a = 0; a < MD; a++) rmem[i][a] <= 16'h0;
      end else if (mwe[i] && phase_at(i, mk[i], mbm[i]) == 1) begin
        if (mbm[i][0]) rmem[i][{mword[i], 1'b0}][7:0]  <= mwd[i][7:0];
        if (mbm[i][1]) rmem[i][{mword[i], 1'b0}][15:8] <= mwd[i][15:8];
      end else if (mwe[i] && phase_at(i, mk[i], mbm[i]) == 2) begin
        if (mbm[i][2]) rmem[i][{mword[i], 1'b1}][7:0]  <= mwd[i][23:16];
        if (mbm[i][3]) rmem[i][{mword[i], 1'b1}][15:8] <= mwd[i][31:24];
      end
      if (!rst_n) begin
        mk[i] <= 0; mwe[i] <= 1'b0; mword[i] <= '0; mwd[i] <= 32'h0;
        mbm[i] <= 4'h0; maddr[i] <= '0; mrd[i] <= 32'h0;
      end else if (mk[i] == 0) begin
        if (req) begin
          mk[i] <= 1; mwe[i] <= we; mword[i] <= addr[AW:2]; mwd[i] <= wdata; mbm[i] <= bmask;
          if (phase_at(i, 1, bmask) == 1) maddr[i] <= {addr[AW:2], 1'b0};
          else if (phase_at(i, 1, bmask) == 2) maddr[i] <= {addr[AW:2], 1'b1};
          else if (!we) mrd[i] <= read_word(i, addr[AW:2], bmask);
        end
      end else if (phase_at(i, mk[i], mbm[i]) == 3) begin
        mk[i] <= 0;
      end else begin
        mk[i] <= mk[i] + 1;
        if (phase_at(i, mk[i] + 1, mbm[i]) == 1) maddr[i] <= {mword[i], 1'b0};
        else if (phase_at(i, mk[i] + 1, mbm[i]) == 2) maddr[i] <= {mword[i], 1'b1};
        else if (!mwe[i]) mrd[i] <= read_word(i, mword[i], mbm[i]);
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h (t=%0t)", nm, inst, act, exp, $time);
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < NI; i++) begin
      int ph;
      logic inph;
      logic [4:0] exp_strb;
      logic [15:0] exp_d;
      ph   = phase_at(i, mk[i], mbm[i]);
      inph = (ph == 1) || (ph == 2);
      exp_strb = 5'b11111;  // {ce, we, oe, ub, lb}
      exp_d = 16'h0;
      if (inph) begin
        exp_strb[4] = 1'b0;
        exp_strb[3] = ~mwe[i];
        exp_strb[2] = mwe[i];
        exp_strb[1:0] = (ph == 1) ? ~mbm[i][1:0] : ~mbm[i][3:2];
        if (mwe[i]) exp_d = (ph == 1) ? mwd[i][15:0] : mwd[i][31:16];
      end
      check("strobes", i, 32'({ce[i], wen[i], oen[i], ubn[i], lbn[i]}), 32'(exp_strb));
      check("sram_addr", i, 32'(sa[i]), 32'(maddr[i]));
      check("sram_d", i, 32'(sd[i]), 32'(exp_d));
      check("ready_busy", i, 32'({rdy[i], busy[i]}), 32'({mk[i] == 0, mk[i] != 0}));
      check("rvalid_wdone", i, 32'({rv[i], wd[i]}), 32'({ph == 3 && !mwe[i], ph == 3 && mwe[i]}));
      check("rdata", i, rdat[i], mrd[i]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    logic        we;
    logic [AW:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] exp_rd;
    logic [2:0][7:0] lat;   // per-instance response latency
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int seen [NI];
    int npulse [NI];
    int wrong [NI];
    int ce_cnt [NI];
    int oe_cnt [NI];
    int cnt = 0;
    while (!(rdy[0] && rdy[1] && rdy[2]) && cnt < 40) begin
      tick();
      cnt++;
    end
    check("idle_wait", idx, 32'(cnt < 40), 32'h1);
    for (int i = 0; i < NI; i++) begin
      seen[i] = 0; npulse[i] = 0; wrong[i] = 0; ce_cnt[i] = 0; oe_cnt[i] = 0;
    end
    req = 1'b1; we = v.we; addr = v.a; wdata = v.d; bmask = v.m;
    tick();
    req = 1'b0; we = ~v.we; addr = 11'($urandom); wdata = $urandom; bmask = 4'($urandom);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      for (int i = 0; i < NI; i++) begin
        if (!ce[i]) ce_cnt[i]++;
        if (!oen[i]) oe_cnt[i]++;
        if (v.we ? rv[i] : wd[i]) wrong[i]++;
        if (v.we ? wd[i] : rv[i]) begin
          npulse[i]++;
          if (seen[i] == 0) seen[i] = c;
          if (!v.we) check($sformatf("vec%0d_rdata", idx), i, rdat[i], v.exp_rd);
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("vec%0d_latency", idx), i, 32'(seen[i]), 32'(v.lat[i]));
      check($sformatf("vec%0d_npulse", idx), i, 32'(npulse[i]), 32'h1);
      check($sformatf("vec%0d_wrong_pulse", idx), i, 32'(wrong[i]), 32'h0);
      check($sformatf("vec%0d_ce_cycles", idx), i, 32'(ce_cnt[i]), 32'(v.lat[i]) - 32'h1);
      check($sformatf("vec%0d_oe_cycles", idx), i, 32'(oe_cnt[i]),
            v.we ? 32'h0 : 32'(v.lat[i]) - 32'h1);
    end
  endtask

  vec_t vecs [12];

  initial begin
    int acc [NI][3];
    int nacc [NI];
    int rv_cnt;

    vecs[0]  = '{1'b0, 11'h008, 32'h0,        4'hF, 32'hA1B2C3D4, {8'd5, 8'd7, 8'd3}};
    vecs[1]  = '{1'b0, 11'h008, 32'h0,        4'hC, 32'hA1B20000, {8'd5, 8'd4, 8'd2}};
    vecs[2]  = '{1'b1, 11'h010, 32'h11223344, 4'h0, 32'h0,        {8'd5, 8'd1, 8'd1}};
    vecs[3]  = '{1'b0, 11'h010, 32'h0,        4'hF, 32'h00000000, {8'd5, 8'd7, 8'd3}};
    vecs[4]  = '{1'b1, 11'h010, 32'h55667788, 4'h5, 32'h0,        {8'd5, 8'd7, 8'd3}};
    vecs[5]  = '{1'b0, 11'h013, 32'h0,        4'hF, 32'h00660088, {8'd5, 8'd7, 8'd3}};
    vecs[6]  = '{1'b0, 11'h010, 32'h0,        4'h3, 32'h00000088, {8'd5, 8'd4, 8'd2}};
    vecs[7]  = '{1'b0, 11'h010, 32'h0,        4'h0, 32'h00000000, {8'd5, 8'd1, 8'd1}};
    vecs[8]  = '{1'b1, 11'h7FC, 32'hDEADBEEF, 4'hF, 32'h0,        {8'd5, 8'd7, 8'd3}};
    vecs[9]  = '{1'b0, 11'h7FF, 32'h0,        4'hF, 32'hDEADBEEF, {8'd5, 8'd7, 8'd3}};
    vecs[10] = '{1'b0, 11'h008, 32'h0,        4'h9, 32'hA10000D4, {8'd5, 8'd7, 8'd3}};
    vecs[11] = '{1'b0, 11'h008, 32'h0,        4'h4, 32'h00B20000, {8'd5, 8'd4, 8'd2}};

    // Reset with a request pending: reset must win.
    req = 1'b1; we = 1'b0; bmask = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0; rst_n = 1'b1; req = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check("rst_ready", i, 32'(rdy[i]), 32'h1);
      check("rst_strobes", i, 32'({ce[i], wen[i], oen[i], ubn[i], lbn[i]}), 32'h1F);
      check("rst_addr", i, 32'(sa[i]), 32'h0);
      check("rst_rdata", i, rdat[i], 32'h0);
    end
    model_check();

    // Full write, checked phase by phase on the zero-wait instance.
    req = 1'b1; we = 1'b1; addr = 11'h008; wdata = 32'hA1B2C3D4; bmask = 4'hF;
    tick();
    req = 1'b0;
    check("w_lo_addr", 0, 32'(sa[0]), 32'h4);
    check("w_lo_data", 0, 32'(sd[0]), 32'hC3D4);
    check("w_lo_ublb_we", 0, 32'({ubn[0], lbn[0], wen[0], oen[0]}), 32'h1);
    tick();
    check("w_hi_addr", 0, 32'(sa[0]), 32'h5);
    check("w_hi_data", 0, 32'(sd[0]), 32'hA1B2);
    tick();
    check("w_done", 0, 32'({wd[0], rv[0]}), 32'h2);
    repeat (6) tick();

    for (int v = 0; v < 12; v++) run_vec(vecs[v], v);

    // Reset during the HI phase of a read (instance 0), with a request present.
    req = 1'b1; we = 1'b0; addr = 11'h008; bmask = 4'hF;
    tick();
    req = 1'b0;
    tick();
    check("pre_rst_hi_addr", 0, 32'(sa[0]), 32'h5);
    rst_n = 1'b0; req = 1'b1;
    tick();
    rst_n = 1'b1; req = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check("midrst_ready", i, 32'(rdy[i]), 32'h1);
      check("midrst_strobes", i, 32'({ce[i], wen[i], oen[i], ubn[i], lbn[i]}), 32'h1F);
      check("midrst_rdata", i, rdat[i], 32'h0);
    end
    rv_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int i = 0; i < NI; i++) if (rv[i] || wd[i]) rv_cnt++;
    end
    check("midrst_no_pulse", 0, 32'(rv_cnt), 32'h0);
    run_vec(vecs[0], 100);

    // Back-to-back reads with request held high.
    for (int i = 0; i < NI; i++) nacc[i] = 0;
    req = 1'b1; we = 1'b0; addr = 11'h010; bmask = 4'hF;
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (req && rdy[i] && nacc[i] < 3) begin
          acc[i][nacc[i]] = c;
          nacc[i]++;
        end
      end
      tick();
    end
    req = 1'b0;
    for (int i = 0; i < NI; i++) begin
      int sp;
      sp = 2 + n_phases(i, 4'hF) * (wc_of(i) + 1);
      check("b2b_accepts", i, 32'(nacc[i]), 32'h3);
      check("b2b_space01", i, 32'(acc[i][1] - acc[i][0]), 32'(sp));
      check("b2b_space12", i, 32'(acc[i][2] - acc[i][1]), 32'(sp));
    end
    repeat (10) tick();

    // Randomised traffic with occasional reset, checked by the model each cycle.
    for (int c = 0; c < 600; c++) begin
      req   = ($urandom_range(0, 2) != 0);
      we    = 1'($urandom);
      addr  = 11'($urandom_range(0, 63));
      wdata = $urandom;
      bmask = 4'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1; req = 1'b0;
    repeat (15) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
